hazard_controller: RTL and testbench

Central stall/flush sequencer for the five-stage RV32I pipeline. Each cycle it decides which pipeline registers load, when ID is flushed (drives `ctrl_hazard` of the decode stage), and when a bubble is injected into ID/EX. Inputs are memory-stall status, EX-stage branch/jump redirects and load-use dependencies. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_controller_if.sv | 40 ++++
 rtl/hazard_controller.sv | 75 +++++++
 tb/tb_hazard_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline hazard status and register-enable bundle
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_valid;
  logic             ex_load;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             imem_pending;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             pc_load;
  logic             if_id_load;
  logic             id_ex_load;
  logic             ex_mem_load;
  logic             mem_wb_load;
  logic             ctrl_hazard;
  logic             ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: reports stage status, receives enables and counters.
  modport master (
    output id_valid, id_rs1, id_rs2, ex_valid, ex_load, ex_rd, ex_redirect,
           imem_pending, imem_resp, dmem_req, dmem_resp,
    input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           ctrl_hazard, ex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, ex_valid, ex_load, ex_rd, ex_redirect,
           imem_pending, imem_resp, dmem_req, dmem_resp,
    output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           ctrl_hazard, ex_bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush sequencer for the five-stage pipeline
module hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_controller_if.slave hz
);
  typedef enum logic {RUN, FLUSH2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall, load_use;
  logic front_en, back_en, hazard, bubble;
  logic stall_inc, flush_inc;

  assign mem_stall = (hz.imem_pending & ~hz.imem_resp) | (hz.dmem_req & ~hz.dmem_resp);
  assign load_use  = hz.ex_valid & hz.ex_load & (hz.ex_rd != 5'd0) & hz.id_valid &
                     ((hz.id_rs1 == hz.ex_rd) | (hz.id_rs2 == hz.ex_rd));

  always_comb begin
    state_d   = state_q;
    front_en  = 1'b1;
    back_en   = 1'b1;
    hazard    = 1'b0;
    bubble    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (mem_stall) begin
      // EX is frozen, so a pending redirect is still visible once the stall clears.
      front_en  = 1'b0;
      back_en   = 1'b0;
      hazard    = (state_q == FLUSH2);
      stall_inc = 1'b1;
    end else if (state_q == RUN && hz.ex_redirect) begin
      hazard    = 1'b1;
      flush_inc = 1'b1;
      state_d   = FLUSH2;
    end else if (state_q == FLUSH2) begin
      hazard  = 1'b1;
      state_d = RUN;
    end else if (load_use) begin
      front_en  = 1'b0;
      bubble    = 1'b1;
      stall_inc = 1'b1;
    end
  end

  assign stall_cnt_d = (stall_inc && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (flush_inc && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_load     = ~rst & front_en;
  assign hz.if_id_load  = ~rst & front_en;
  assign hz.id_ex_load  = ~rst & back_en;
  assign hz.ex_mem_load = ~rst & back_en;
  assign hz.mem_wb_load = ~rst & back_en;
  assign hz.ctrl_hazard = ~rst & hazard;
  assign hz.ex_bubble   = ~rst & bubble;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed bench for hazard_controller
module tb_hazard_controller;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  hazard_controller_if #(.CNT_W(CNT_W)) hif ();

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packed as {pc, if_id, id_ex, ex_mem, mem_wb, ctrl_hazard, ex_bubble}.
  task automatic chk_out(input string tag, input logic [4:0] en, input logic hzd, input logic bub);
    chk(tag, {25'd0, hif.pc_load, hif.if_id_load, hif.id_ex_load, hif.ex_mem_load,
              hif.mem_wb_load, hif.ctrl_hazard, hif.ex_bubble}, {25'd0, en, hzd, bub});
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f);
    chk({tag, "_stall"}, {28'd0, hif.stall_cnt}, s[31:0]);
    chk({tag, "_flush"}, {28'd0, hif.flush_cnt}, f[31:0]);
  endtask

  task automatic idle();
    hif.id_valid = 0; hif.id_rs1 = 0; hif.id_rs2 = 0;
    hif.ex_valid = 0; hif.ex_load = 0; hif.ex_rd = 0; hif.ex_redirect = 0;
    hif.imem_pending = 0; hif.imem_resp = 0; hif.dmem_req = 0; hif.dmem_resp = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    hif.ex_valid = 1; hif.ex_load = 1; hif.ex_rd = rd;
    hif.id_valid = 1; hif.id_rs1 = rs1; hif.id_rs2 = rs2;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    hif.ex_redirect = 1;
    #1;
    chk_out("reset_out", 5'b00000, 0, 0);
    chk_cnt("reset", 0, 0);

    next(); rst = 0; #1;
    chk_out("run_idle", 5'b11111, 0, 0);

    next(); set_load_use(5'd5, 5'd0, 5'd5); #1;
    chk_out("load_use", 5'b00111, 0, 1);
    next(); hif.ex_valid = 1; #1;
    chk_out("load_use_after", 5'b11111, 0, 0);
    chk_cnt("lu", 1, 0);

    next(); set_load_use(5'd0, 5'd0, 5'd3); #1;
    chk_out("rd_zero", 5'b11111, 0, 0);

    next(); hif.ex_redirect = 1; #1;
    chk_out("redir_c1", 5'b11111, 1, 0);
    next(); #1;
    chk_out("redir_c2", 5'b11111, 1, 0);
    chk_cnt("redir", 1, 1);
    next(); #1;
    chk_out("redir_c3", 5'b11111, 0, 0);

    next(); hif.ex_redirect = 1; #1;
    chk_out("rs_c1", 5'b11111, 1, 0);
    for (int i = 0; i < 3; i++) begin
      next(); hif.dmem_req = 1; #1;
      chk_out("rs_stall", 5'b00000, 1, 0);
    end
    next(); #1;
    chk_out("rs_flush2", 5'b11111, 1, 0);
    next(); #1;
    chk_out("rs_run", 5'b11111, 0, 0);
    chk_cnt("rs", 4, 2);

    next(); set_load_use(5'd7, 5'd7, 5'd0); hif.ex_redirect = 1; #1;
    chk_out("redir_lu_c1", 5'b11111, 1, 0);
    next(); set_load_use(5'd7, 5'd7, 5'd0); #1;
    chk_out("redir_lu_c2", 5'b11111, 1, 0);
    next(); #1;
    chk_cnt("redir_lu", 4, 3);

    next(); hif.imem_pending = 1; hif.ex_redirect = 1; #1;
    chk_out("defer_stall", 5'b00000, 0, 0);
    next(); hif.imem_pending = 1; hif.imem_resp = 1; hif.ex_redirect = 1; #1;
    chk_out("defer_redir", 5'b11111, 1, 0);
    next(); hif.ex_redirect = 1; #1;
    chk_out("flush2_ignores", 5'b11111, 1, 0);
    next(); #1;
    chk_out("defer_run", 5'b11111, 0, 0);
    chk_cnt("defer", 5, 4);

    next(); hif.ex_redirect = 1;
    next(); #2; rst = 1; #1;
    chk_out("rst_mid_out", 5'b00000, 0, 0);
    chk_cnt("rst_mid", 0, 0);
    next(); rst = 0; #1;
    chk_out("rst_mid_after", 5'b11111, 0, 0);

    for (int i = 0; i < 17; i++) begin
      next(); set_load_use(5'd9, 5'd9, 5'd9);
    end
    next(); #1;
    chk_cnt("sat", 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
